// File: rtl/edn_pkg.sv
// Shared EDN endpoint types: request/acknowledge bundle between the EDN and its consumers.
package edn_pkg;

    parameter int unsigned ENDPOINT_BUS_WIDTH = 32;

    typedef struct packed {
        logic edn_req;
    } edn_req_t;

    typedef struct packed {
        logic                          edn_ack;
        logic                          edn_fips;
        logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
    } edn_rsp_t;

endpackage

// File: rtl/edn_endpoint_rsp.sv
// EDN endpoint responder: unpacks wide entropy blocks into bus words and
// answers each endpoint request with a single-cycle acknowledge.
module edn_endpoint_rsp
    import edn_pkg::*;
#(
    parameter int unsigned InW  = 128,
    parameter int unsigned BusW = edn_pkg::ENDPOINT_BUS_WIDTH
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           enable_i,
    input  logic           src_valid_i,
    output logic           src_ready_o,
    input  logic [InW-1:0] src_bits_i,
    input  logic           src_fips_i,
    input  edn_req_t       edn_i,
    output edn_rsp_t       edn_o,
    output logic           err_o,
    input  logic           err_clr_i
);

    localparam int unsigned NumWords = InW / BusW;
    localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    typedef enum logic {
        ST_EMPTY,
        ST_AVAIL
    } state_e;

    state_e                       state_q;
    logic [IdxW-1:0]              idx_q;
    logic [NumWords-1:0][BusW-1:0] buf_q;
    logic                         buf_fips_q;
    logic                         ack_q;
    logic                         fips_q;
    logic [BusW-1:0]              bus_q;
    logic                         out_q;
    logic                         err_q;
    logic                         ack_d;
    logic                         out_d;

    // Acks are blanked while the previous ack is still high.
    always_comb begin
        ack_d = (state_q == ST_AVAIL) & enable_i & edn_i.edn_req & ~ack_q;
    end

    // A withdrawn request is no longer outstanding, so the error fires once
    // per withdrawal and err_clr_i can take effect afterwards.
    always_comb begin
        out_d = edn_i.edn_req & (out_q | ~ack_q) & ~ack_d;
    end

    assign src_ready_o = rst_ni & enable_i & (state_q == ST_EMPTY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            idx_q      <= '0;
            buf_q      <= '0;
            buf_fips_q <= 1'b0;
            ack_q      <= 1'b0;
            fips_q     <= 1'b0;
            bus_q      <= '0;
            out_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (out_q && !edn_i.edn_req) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q    <= ST_EMPTY;
                idx_q      <= '0;
                buf_q      <= '0;
                buf_fips_q <= 1'b0;
                ack_q      <= 1'b0;
                out_q      <= 1'b0;
            end else begin
                ack_q <= ack_d;
                out_q <= out_d;
                case (state_q)
                    ST_EMPTY: begin
                        if (src_valid_i) begin
                            buf_q      <= src_bits_i;
                            buf_fips_q <= src_fips_i;
                            idx_q      <= '0;
                            state_q    <= ST_AVAIL;
                        end
                    end
                    ST_AVAIL: begin
                        if (ack_d) begin
                            bus_q  <= buf_q[idx_q];
                            fips_q <= buf_fips_q;
                            if (idx_q == LastIdx) begin
                                idx_q   <= '0;
                                state_q <= ST_EMPTY;
                            end else begin
                                idx_q <= idx_q + IdxW'(1);
                            end
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign edn_o.edn_ack  = ack_q;
    assign edn_o.edn_fips = fips_q;
    assign edn_o.edn_bus  = bus_q;
    assign err_o          = err_q;

endmodule
